// File: rtl/uart_rx_ctrl.sv
// Sequencer and output FIFO for a single UART receiver, with error/overrun/timeout status.
// Optional receive timeout and ABORT state are built only when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH          = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctrl_enable_i,
  input  logic                       clear_status_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_data_ready_i,
  input  logic                       rx_receiving_i,
  output logic                       rx_enable_o,
  output logic [7:0]                 out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       overrun_o,
  output logic [7:0]                 err_count_o,
  output logic                       timeout_flag_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StOff, StArmed, StRecv, StAbort} state_e;

  state_e          state_q, state_d;
  logic            rx_recv_q;
  logic            timeout_fire;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      err_q, err_d;
  logic            full, pop, push_acc, frame_fail;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff:   if (ctrl_enable_i) state_d = StArmed;
      StArmed: if (rx_receiving_i) state_d = StRecv;
      StRecv: begin
        if (timeout_fire)        state_d = StAbort;
        else if (!rx_receiving_i) state_d = StArmed;
      end
      StAbort: state_d = StArmed;
      default: state_d = StOff;
    endcase
    if (!ctrl_enable_i) state_d = StOff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StOff;
      rx_recv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_recv_q <= rx_receiving_i;
    end
  end

  assign rx_enable_o = (state_q == StArmed) || (state_q == StRecv);

  // Only a falling edge seen while RECEIVING is a real frame end; ABORT/OFF drops are ignored.
  assign frame_fail = (state_q == StRecv) && rx_recv_q && !rx_receiving_i && !rx_data_ready_i;

  assign full     = (count_q == CW'(DEPTH));
  assign pop      = out_ready_i && (count_q != '0);
  assign push_acc = rx_data_ready_i && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop)      count_d = count_q + CW'(1);
    else if (!push_acc && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    overrun_d = overrun_q;
    if (rx_data_ready_i && full && !pop) overrun_d = 1'b1;
    else if (clear_status_i)             overrun_d = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (frame_fail) begin
      if (clear_status_i)      err_d = 8'd1;
      else if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end else if (clear_status_i) begin
      err_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      err_q     <= 8'd0;
    end else begin
      if (push_acc) begin
        mem_q[tail_q] <= rx_data_i;
        tail_q        <= tail_q + PW'(1);
      end
      if (pop) head_q <= head_q + PW'(1);
      count_q   <= count_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  assign out_data_o   = mem_q[head_q];
  assign out_valid_o  = (count_q != '0);
  assign fifo_count_o = count_q;
  assign overrun_o    = overrun_q;
  assign err_count_o  = err_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        timeout_flag_q;

  assign timeout_fire = (state_q == StRecv) && (to_cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q       <= 16'd0;
      timeout_flag_q <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == StRecv) ? to_cnt_q + 16'd1 : 16'd0;
      // Flag only when the abort really happens (OFF takes priority over it).
      if (state_d == StAbort)  timeout_flag_q <= 1'b1;
      else if (clear_status_i) timeout_flag_q <= 1'b0;
    end
  end

  assign timeout_flag_o = timeout_flag_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_fire   = 1'b0;
  assign timeout_flag_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl_enable, clear_status, rx_data_ready, rx_receiving, out_ready;
  logic [7:0] rx_data;
  logic       rx_enable, out_valid, overrun, timeout_flag;
  logic [7:0] out_data, err_count;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH(4),
    .TIMEOUT_CYCLES(16'd16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_enable_i  (ctrl_enable),
    .clear_status_i (clear_status),
    .rx_data_i      (rx_data),
    .rx_data_ready_i(rx_data_ready),
    .rx_receiving_i (rx_receiving),
    .rx_enable_o    (rx_enable),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .fifo_count_o   (fifo_count),
    .overrun_o      (overrun),
    .err_count_o    (err_count),
    .timeout_flag_o (timeout_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b; rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctrl_enable = 0; clear_status = 0; rx_data = 0;
    rx_data_ready = 0; rx_receiving = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("rst_rx_enable", 32'(rx_enable), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_timeout", 32'(timeout_flag), 0);

    ctrl_enable = 1'b1;
    step();
    chk("arm_rx_enable", 32'(rx_enable), 1);

    // Good frame carrying A5
    rx_receiving = 1'b1;
    step();
    rx_receiving = 1'b0; rx_data = 8'hA5; rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
    chk("good_valid", 32'(out_valid), 1);
    chk("good_data", 32'(out_data), 32'hA5);
    chk("good_count", 32'(fifo_count), 1);
    chk("good_no_err", 32'(err_count), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_count", 32'(fifo_count), 0);
    chk("pop_valid", 32'(out_valid), 0);

    // Fill past capacity
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("full_overrun_pre", 32'(overrun), 0);
    push(8'h55);
    chk("full_count", 32'(fifo_count), 4);
    chk("full_overrun", 32'(overrun), 1);
    chk("full_head", 32'(out_data), 32'h11);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("clr_overrun", 32'(overrun), 0);
    chk("clr_keeps_count", 32'(fifo_count), 4);

    // Push and pop together while full
    rx_data = 8'h66; rx_data_ready = 1'b1; out_ready = 1'b1;
    step();
    rx_data_ready = 1'b0; out_ready = 1'b0;
    chk("pp_count", 32'(fifo_count), 4);
    chk("pp_overrun", 32'(overrun), 0);
    chk("pp_head", 32'(out_data), 32'h22);
    out_ready = 1'b1;
    step(); chk("drain_33", 32'(out_data), 32'h33);
    step(); chk("drain_44", 32'(out_data), 32'h44);
    step(); chk("drain_66", 32'(out_data), 32'h66);
    step();
    chk("drain_count", 32'(fifo_count), 0);
    chk("drain_valid", 32'(out_valid), 0);
    step();
    out_ready = 1'b0;
    chk("empty_pop_count", 32'(fifo_count), 0);

    // Failed frames, saturation and clear collision
    for (int i = 0; i < 300; i++) begin
      rx_receiving = 1'b1; step();
      rx_receiving = 1'b0; step();
      if (i == 1) chk("err_two", 32'(err_count), 2);
    end
    chk("err_sat", 32'(err_count), 255);
    rx_receiving = 1'b1; step();
    rx_receiving = 1'b0; clear_status = 1'b1; step();
    clear_status = 1'b0;
    chk("err_clr_collide", 32'(err_count), 1);
    clear_status = 1'b1; step();
    clear_status = 1'b0;
    chk("err_clr", 32'(err_count), 0);

    // Disable mid-frame: no error, FIFO kept
    push(8'h77);
    rx_receiving = 1'b1; step();
    ctrl_enable = 1'b0; step();
    chk("off_rx_enable", 32'(rx_enable), 0);
    rx_receiving = 1'b0; step();
    chk("off_no_err", 32'(err_count), 0);
    chk("off_keep_valid", 32'(out_valid), 1);
    chk("off_keep_data", 32'(out_data), 32'h77);
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    chk("off_drain", 32'(fifo_count), 0);
    ctrl_enable = 1'b1; step();
    chk("rearm", 32'(rx_enable), 1);

`ifdef UART_RX_CTRL_TIMEOUT_EN
    rx_receiving = 1'b1; step();
    repeat (15) step();
    chk("to_still_on", 32'(rx_enable), 1);
    chk("to_flag_pre", 32'(timeout_flag), 0);
    step();
    chk("to_abort_off", 32'(rx_enable), 0);
    chk("to_flag", 32'(timeout_flag), 1);
    rx_receiving = 1'b0; step();
    chk("to_rearm", 32'(rx_enable), 1);
    chk("to_no_err", 32'(err_count), 0);
    clear_status = 1'b1; step();
    clear_status = 1'b0;
    chk("to_flag_clr", 32'(timeout_flag), 0);
`else
    rx_receiving = 1'b1;
    repeat (20) step();
    chk("nto_rx_enable", 32'(rx_enable), 1);
    chk("nto_flag", 32'(timeout_flag), 0);
    rx_receiving = 1'b0; step();
    chk("nto_err", 32'(err_count), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences one UART receiver instance and buffers its output for a host. It owns the receiver's `enable` input and watches the receiver's `data_ready`, `data_out` and `receiving` outputs. Good bytes go into a small FIFO that the host drains with a valid/ready handshake. It also counts failed frames and keeps sticky overrun and timeout status flags.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT_CYCLES`, default 16'd2000: clock cycles `rx_receiving` may stay high before a forced abort. Used only with `UART_RX_CTRL_TIMEOUT_EN`.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `ctrl_enable`  in  1: host enable for reception.
- `clear_status`  in  1: one-cycle pulse; clears `overrun`, `timeout_flag` and `err_count`.
- `rx_data`  in  8: receiver `data_out`.
- `rx_data_ready`  in  1: receiver `data_ready`, a one-cycle pulse.
- `rx_receiving`  in  1: receiver `receiving`.
- `rx_enable`  out  1: drives receiver `enable`.
- `out_data`  out  8: FIFO head byte.
- `out_valid`  out  1: FIFO is not empty.
- `out_ready`  in  1: host pops the head when `out_valid` and `out_ready` are both high.
- `fifo_count`  out  $clog2(DEPTH)+1: current occupancy.
- `overrun`  out  1: sticky; a byte was dropped because the FIFO was full.
- `err_count`  out  8: saturating count of failed frames.
- `timeout_flag`  out  1: sticky; a receive timeout abort occurred.

## Operation
- **Reset values:** state OFF; `rx_enable`=0; `out_valid`=0; `out_data`=0 (memory cleared); `fifo_count`=0; `overrun`=0; `err_count`=0; `timeout_flag`=0.
- **States:** OFF, ARMED, RECEIVING, ABORT. `rx_enable` is 1 only in ARMED or RECEIVING, decoded from the registered state.
- **State transitions:**
  - OFF→ARMED when `ctrl_enable`=1.
  - ARMED→RECEIVING when `rx_receiving`=1.
  - RECEIVING→ARMED when `rx_receiving`=0.
  - RECEIVING→ABORT when the timeout fires.
  - ABORT→ARMED after exactly one cycle.
  - Any state→OFF when `ctrl_enable`=0; this has priority over all other transitions.
- **Frame end:** detected when the registered `rx_receiving` is 1 and the current value is 0, in state RECEIVING.
  - If `rx_data_ready`=1 in that cycle, it is a good byte.
  - Otherwise it is a failed frame: `err_count` increments, saturating at 255.
  - A falling edge caused by ABORT or OFF does not count as a failed frame.
- **Push:** on any `rx_data_ready`=1, `rx_data` is written at the tail.
  - If the FIFO is full and no pop happens in the same cycle, the byte is dropped and `overrun` is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted, `fifo_count` is unchanged and `overrun` is not set.
- **Pop:** `out_data` is the head read combinationally from memory; the pop advances the head pointer. A pop on an empty FIFO is ignored.
- **Pointers:** `$clog2(DEPTH)` bits each, natural wrap-around.
- **Timeout counter:** counts cycles while in RECEIVING and clears on any other state. When it reaches `TIMEOUT_CYCLES-1`, the next state is ABORT and `timeout_flag` is set.
- **`clear_status`:** if a set or increment event happens in the same cycle, the event wins.
  - `overrun` and `timeout_flag` end at 1.
  - `err_count` ends at 1.
- **`ctrl_enable`=0:** reception stops, but FIFO contents are kept and the host can still drain them.

## Timing
- `ctrl_enable` rising at edge N: state becomes ARMED and `rx_enable`=1 after edge N.
- `ctrl_enable` falling at edge N: `rx_enable`=0 after edge N. A frame in progress is discarded by the receiver and no error is counted.
- `rx_data_ready` sampled at edge N: after edge N, `fifo_count` is updated and `out_valid`=1 (if the FIFO was empty) with `out_data` equal to the byte.
- Pop at edge N: `fifo_count` decrements and `out_data` shows the next entry after edge N.
- ABORT holds `rx_enable`=0 for exactly one cycle, which is enough to reset the receiver; the next state is ARMED.
- `err_count` and status flags update at the edge that samples their event.

## Configuration
- **Macro `UART_RX_CTRL_TIMEOUT_EN`:**
  - Defined: the timeout counter and the ABORT state are implemented as described above.
  - Undefined: no counter is built, ABORT is unreachable, `timeout_flag` is tied to 0 and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Reset then `ctrl_enable`=1 → `rx_enable`=1 one cycle later; `fifo_count`=0, `err_count`=0, both flags 0.
- `rx_receiving` 1→0 with `rx_data_ready` pulse and `rx_data`=8'hA5, `out_ready`=0 → `out_valid`=1, `out_data`=A5, `fifo_count`=1; then `out_ready`=1 for one cycle → `fifo_count`=0, `out_valid`=0.
- DEPTH=4: push 11,22,33,44,55 with no pops → `fifo_count`=4, `overrun`=1; popping yields 11,22,33,44.
- With the FIFO full, push 66 and pop in the same cycle → `fifo_count`=4, `overrun` unchanged, last popped entry is 66.
- 300 frame ends without `rx_data_ready` → `err_count`=255. Then `clear_status` coinciding with one more failed frame → `err_count`=1.
- `UART_RX_CTRL_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16, `rx_receiving` held at 1 → `rx_enable`=0 for one cycle 16 cycles after entering RECEIVING, `timeout_flag`=1, `err_count` unchanged.
